// File: rtl/line_mem_responder_if.sv
// Line-memory handshake between a cache (master) and a line memory (slave).
// mem_addr is a line address: byte-offset bits [3:0] are not carried.
interface line_mem_responder_if;
    logic          mem_read;
    logic          mem_write;
    logic [31:4]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency line-memory responder backed by an on-chip array of 128-bit lines.
// Exposes saturating read/write completion counters and a sticky protocol-error flag.
module line_mem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 8   // legal range 1..255
) (
    input  logic                   clk,
    input  logic                   rst,
    line_mem_responder_if.slave    bus,
    output logic                   busy,
    output logic                   proto_err,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam int unsigned Lines   = 2 ** ADDR_W;
    localparam logic [7:0]  LoadCnt = 8'(LATENCY - 1);

    state_e              state_q;
    logic [7:0]          cnt_q;
    logic                op_wr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [127:0]        wdata_q;
    logic [127:0]        rdata_q;
    logic                ready_q;
    logic                perr_q;
    logic [15:0]         rd_cnt_q;
    logic [15:0]         wr_cnt_q;

    logic [127:0]        mem_q [Lines];

    logic                req;
    logic [ADDR_W-1:0]   req_idx;
    logic                unused_addr;

    assign req         = bus.mem_read | bus.mem_write;
    assign req_idx     = bus.mem_addr[ADDR_W+3:4];
    // Upper address bits are deliberately ignored so lines alias.
    assign unused_addr = ^bus.mem_addr;

    // Request FSM: accept in idle, count down the latency, pulse ready for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            op_wr_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= 128'd0;
            rdata_q  <= 128'd0;
            ready_q  <= 1'b0;
            perr_q   <= 1'b0;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        // Write wins when both are asserted; no read is performed.
                        op_wr_q <= bus.mem_write;
                        idx_q   <= req_idx;
                        wdata_q <= bus.mem_wdata;
                        cnt_q   <= LoadCnt;
                        if (bus.mem_read && bus.mem_write) begin
                            perr_q <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            state_q <= StDone;
                            ready_q <= 1'b1;
                            if (!bus.mem_write) begin
                                rdata_q <= mem_q[req_idx];
                            end
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    // Request inputs are not looked at here; the access is already latched.
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= StDone;
                        ready_q <= 1'b1;
                        if (!op_wr_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                    end
                end
                StDone: begin
                    // A request still held here is only re-evaluated back in idle.
                    ready_q <= 1'b0;
                    state_q <= StIdle;
                    if (op_wr_q) begin
                        if (wr_cnt_q != 16'hFFFF) begin
                            wr_cnt_q <= wr_cnt_q + 16'd1;
                        end
                    end else begin
                        if (rd_cnt_q != 16'hFFFF) begin
                            rd_cnt_q <= rd_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Line array: written at the edge ending the done cycle; reset discards the write
    // but never clears the contents.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StDone && op_wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;
    assign busy          = (state_q != StIdle);
    assign proto_err     = perr_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized bench for line_mem_responder: a timeline model (acceptance cycle +
// latency) predicts every output each cycle; directed literal checks pin the model.
module tb_line_mem_responder;

    localparam int unsigned LAT = 8;
    localparam int unsigned AW  = 8;
    localparam int unsigned NL  = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst1;
    logic        busy, perr, busy1, perr1;
    logic [15:0] rdc, wrc, rdc1, wrc1;

    line_mem_responder_if bus ();
    line_mem_responder_if bus1 ();

    line_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .proto_err (perr),
        .rd_count  (rdc),
        .wr_count  (wrc)
    );

    line_mem_responder #(.ADDR_W(4), .LATENCY(1)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .bus       (bus1),
        .busy      (busy1),
        .proto_err (perr1),
        .rd_count  (rdc1),
        .wr_count  (wrc1)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           cyc = 0;
    bit           pend = 1'b0;
    int           done_cyc;
    bit           pw;
    int           pidx;
    logic [127:0] pdata;
    logic [127:0] mmem [NL];
    logic         e_ready, e_busy, e_perr;
    logic [127:0] e_rdata;
    int           e_rd, e_wr;
    bit           m_idle;

    // An access accepted at cycle c completes (ready high) in cycle c+LAT; the array and
    // counters update when that cycle ends.
    always @(posedge clk) begin
        if (rst) begin
            pend    = 1'b0;
            e_ready = 1'b0;
            e_busy  = 1'b0;
            e_perr  = 1'b0;
            e_rdata = 128'd0;
            e_rd    = 0;
            e_wr    = 0;
        end else begin
            m_idle = !pend;
            if (pend && cyc == done_cyc) begin
                if (pw) begin
                    mmem[pidx] = pdata;
                    if (e_wr < 65535) e_wr++;
                end else if (e_rd < 65535) begin
                    e_rd++;
                end
                pend = 1'b0;
            end
            if (m_idle && (bus.mem_read || bus.mem_write)) begin
                pend     = 1'b1;
                done_cyc = cyc + LAT;
                pw       = bus.mem_write;
                pidx     = int'(bus.mem_addr[AW+3:4]);
                pdata    = bus.mem_wdata;
                if (bus.mem_read && bus.mem_write) e_perr = 1'b1;
            end
            e_ready = pend && (cyc + 1 == done_cyc);
            if (e_ready && !pw) e_rdata = mmem[pidx];
            e_busy = pend;
        end
        cyc++;
    end

    // Compare every DUT output against the model in every cycle after the first reset.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_ready", {127'd0, bus.mem_ready}, {127'd0, e_ready});
            chk("busy", {127'd0, busy}, {127'd0, e_busy});
            chk("proto_err", {127'd0, perr}, {127'd0, e_perr});
            chk("mem_rdata", bus.mem_rdata, e_rdata);
            chk("rd_count", {112'd0, rdc}, 128'(e_rd));
            chk("wr_count", {112'd0, wrc}, 128'(e_wr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drop_req();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    // Issue one request; lat = cycles from first-seen to ready, or -1 if ready never pulses.
    // mid: drop the request and scramble addr/data in cycle 3.
    // rst_at: if nonzero, pulse reset in that cycle of the access.
    task automatic do_req(input bit rd, input bit wr, input logic [27:0] a,
                          input logic [127:0] d, input bit mid, input int rst_at,
                          output int lat);
        int c0;
        lat = -1;
        @(posedge clk); #1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        c0 = cyc;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) begin
                lat = cyc - c0;
                break;
            end
            if (rst_at != 0 && cyc - c0 >= rst_at + int'(LAT) + 2) break;
            @(posedge clk); #1;
            if (mid && cyc == c0 + 3) begin
                drop_req();
                bus.mem_addr  = ~a;
                bus.mem_wdata = ~d;
            end
            if (rst_at != 0 && cyc == c0 + rst_at) begin
                rst = 1'b1;
                drop_req();
            end else begin
                rst = 1'b0;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drop_req();
        if (rst_at == 0) chk("req_completes", {127'd0, lat >= 0}, 128'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected finish by 60000 cycles");
        $fatal(1);
    end

    logic [127:0] d1, d2, d3, v1, v2, aa, rdata1;
    logic [5:0]   pat_w;
    logic [3:0]   pat_r;
    int           lat, kind, rst_at;
    bit           rd, wr, mid;
    logic [27:0]  a;
    logic [127:0] d;

    initial begin
        rst            = 1'b1;
        rst1           = 1'b1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus1.mem_read  = 1'b0;
        bus1.mem_write = 1'b0;
        bus1.mem_addr  = '0;
        bus1.mem_wdata = '0;
        d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        d2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        d3 = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;
        v1 = {16{8'h11}};
        v2 = {16{8'h22}};
        aa = {16{8'hAA}};

        do_reset();
        chk_en = 1'b1;

        // Preload every line so later reads are fully predictable.
        for (int i = 0; i < int'(NL); i++) begin
            do_req(1'b0, 1'b1, {20'($urandom), 8'(i)},
                   {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, lat);
        end
        do_reset();

        // Reset state.
        @(negedge clk);
        chk("rst_ready", {127'd0, bus.mem_ready}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_rdata", bus.mem_rdata, 128'd0);
        chk("rst_counts", {96'd0, rdc, wrc}, 128'd0);

        // Write then read, latency 8.
        do_req(1'b0, 1'b1, 28'h0000001, d1, 1'b0, 0, lat);
        chk("wr_latency", 128'(lat), 128'(8));
        do_req(1'b1, 1'b0, 28'h0000001, 128'd0, 1'b0, 0, lat);
        chk("rd_latency", 128'(lat), 128'(8));
        @(negedge clk);
        chk("rd_data_d1", bus.mem_rdata, d1);
        chk("counts_1_1", {96'd0, rdc, wrc}, {96'd0, 16'd1, 16'd1});

        // Read and write together: write wins, error is sticky.
        do_req(1'b1, 1'b1, 28'h0000005, aa, 1'b0, 0, lat);
        @(negedge clk);
        chk("perr_set", {127'd0, perr}, 128'd1);
        chk("counts_1_2", {96'd0, rdc, wrc}, {96'd0, 16'd1, 16'd2});
        do_req(1'b1, 1'b0, 28'h0000005, 128'd0, 1'b0, 0, lat);
        @(negedge clk);
        chk("rd_data_aa", bus.mem_rdata, aa);
        chk("perr_sticky", {127'd0, perr}, 128'd1);

        // Inputs changed mid-wait do not disturb the latched write.
        do_req(1'b0, 1'b1, 28'h0000009, d2, 1'b1, 0, lat);
        chk("mid_latency", 128'(lat), 128'(8));
        do_req(1'b1, 1'b0, 28'h0000009, 128'd0, 1'b0, 0, lat);
        @(negedge clk);
        chk("rd_data_d2", bus.mem_rdata, d2);

        // Reset mid-wait discards the write.
        do_req(1'b0, 1'b1, 28'h0000007, v1, 1'b0, 0, lat);
        do_req(1'b0, 1'b1, 28'h0000007, v2, 1'b0, 4, lat);
        chk("rst_no_ready", 128'(lat), 128'(-1));
        @(negedge clk);
        chk("rst_counts_zero", {96'd0, rdc, wrc}, 128'd0);
        chk("rst_perr_zero", {127'd0, perr}, 128'd0);
        do_req(1'b1, 1'b0, 28'h0000007, 128'd0, 1'b0, 0, lat);
        chk("post_rst_latency", 128'(lat), 128'(8));
        @(negedge clk);
        chk("rd_data_v1", bus.mem_rdata, v1);

        // Aliasing through ignored upper address bits.
        do_req(1'b0, 1'b1, 28'h0000100, d3, 1'b0, 0, lat);
        do_req(1'b1, 1'b0, 28'h0000000, 128'd0, 1'b0, 0, lat);
        @(negedge clk);
        chk("alias_data", bus.mem_rdata, d3);

        // Randomized traffic including both-high requests and resets at random points.
        for (int t = 0; t < 200; t++) begin
            kind   = int'($urandom_range(0, 99));
            rd     = (kind < 45) || (kind >= 85 && kind < 92);
            wr     = (kind >= 45);
            a      = 28'($urandom);
            d      = {$urandom, $urandom, $urandom, $urandom};
            mid    = ($urandom_range(0, 3) == 0);
            rst_at = (kind >= 92) ? int'($urandom_range(1, LAT)) : 0;
            do_req(rd, wr, a, d, mid, rst_at, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Latency-1 instance: request held high is accepted every other cycle.
        @(posedge clk); #1;
        rst1 = 1'b0;
        bus1.mem_write = 1'b1;
        bus1.mem_addr  = 28'h0000000;
        bus1.mem_wdata = d1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pat_w[k] = bus1.mem_ready;
            @(posedge clk); #1;
        end
        bus1.mem_write = 1'b0;
        bus1.mem_read  = 1'b1;
        rdata1 = 128'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pat_r[k] = bus1.mem_ready;
            if (k == 1) rdata1 = bus1.mem_rdata;
            @(posedge clk); #1;
        end
        bus1.mem_read = 1'b0;
        @(negedge clk);
        chk("lat1_wr_pattern", {122'd0, pat_w}, {122'd0, 6'b101010});
        chk("lat1_rd_pattern", {124'd0, pat_r}, {124'd0, 4'b1010});
        chk("lat1_rdata", rdata1, d1);
        chk("lat1_counts", {96'd0, rdc1, wrc1}, {96'd0, 16'd2, 16'd3});

        @(posedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Synthesizable responder for the 128-bit line-memory handshake (mem_read / mem_write / mem_addr[31:4] / mem_wdata / mem_rdata / mem_ready) that the CHIP I-cache and D-cache drive. It replaces the behavioural slow memory on either port in synthesized or FPGA builds. Each request takes a fixed, parameterized latency and is served from an on-chip line array. The block also exposes access counters and a sticky protocol-error flag for the TestBed.

## Interface
- ADDR_W, 8: index bits taken from mem_addr[ADDR_W+3:4]; the array holds 2^ADDR_W lines of 128 bits.
- LATENCY, 8: cycles from request acceptance to mem_ready; legal range 1..255.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  line read request.
- mem_write  input  1  line write request.
- mem_addr  input  28 ([31:4])  line address.
- mem_wdata  input  128  write data, sampled at acceptance.
- mem_rdata  output  128  read data; valid in the mem_ready cycle of a read; held otherwise.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is latched and incomplete.
- proto_err  output  1  sticky violation flag.
- rd_count  output  16  completed reads, saturating at 0xFFFF.
- wr_count  output  16  completed writes, saturating at 0xFFFF.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - If mem_read or mem_write is high, latch op, index (mem_addr[ADDR_W+3:4]) and mem_wdata.
  - Load the down-counter with LATENCY-1, then go to WAIT; if LATENCY==1, go straight to DONE.
- WAIT:
  - Decrement the counter; at 0, go to DONE.
  - Request inputs are ignored: address and data changes, or dropping the request, do not affect the latched access.
- DONE (one cycle):
  - mem_ready=1.
  - Read: mem_rdata = array[index], registered so it is valid throughout the DONE cycle.
  - Write: array[index] <= latched wdata at the edge that ends DONE.
  - Increment the matching counter (saturating).
  - Next state is IDLE.
- Simultaneous mem_read and mem_write at acceptance: set proto_err; the write wins and no read is performed.
- Request still high in the DONE cycle: ignored. It is re-evaluated in IDLE on the following cycle as a new request; requesters must drop the request on seeing mem_ready.
- Upper address bits above ADDR_W+3 are ignored, so addresses alias.
- busy = (state != IDLE).

## Timing
- Request first seen high in IDLE at cycle 0 → mem_ready high in cycle LATENCY only, low in all other cycles.
- Back-to-back: the next request is accepted at the earliest in cycle LATENCY+1, giving a minimum spacing of LATENCY+1 cycles between accepted requests.
- Read-after-write to the same line, accepted after the write's DONE, returns the new data.
- Reset (any cycle, including mid-WAIT or DONE):
  - State returns to IDLE; mem_ready=0, busy=0, mem_rdata=0, proto_err=0, rd_count=0, wr_count=0.
  - A pending write is discarded; the array contents are not cleared.
  - A request high in the cycle after rst falls is accepted normally.
- mem_rdata changes only at the edge entering DONE for a read, or on reset.

## Test plan
- Write then read, LATENCY=8: write 0x0123…CDEF to mem_addr=0x0000001, then read the same address → mem_ready pulses once in cycle 8 of each access; read returns 0x0123…CDEF; wr_count=1, rd_count=1.
- LATENCY=1: read accepted in cycle 0 → mem_ready in cycle 1 → next request accepted no earlier than cycle 2.
- Read and write both high on index 5, wdata=0xAA…AA → proto_err=1 and stays 1; wr_count increments and rd_count does not; a later read of index 5 returns 0xAA…AA.
- Mid-WAIT changes: write accepted, then mem_addr changed and mem_write dropped in cycle 3 → write still completes to the original address in cycle 8.
- Reset mid-WAIT of a write to index 7 → no mem_ready; index 7 keeps its old value; counters=0; next read completes after the full latency.
- Aliasing with ADDR_W=8: write to mem_addr=0x0000100, read mem_addr=0x0000000 → same data returned.
